// File: rtl/int_sum_ctrl_if.sv
// int_sum_ctrl_if: upstream/downstream valid-ready handshake of the window-sum pipeline.
interface int_sum_ctrl_if;
    logic sq_pd_pvld;
    logic sq_pd_prdy;
    logic sum_out_pvld;
    logic sum_out_prdy;
    modport master (output sq_pd_pvld, sum_out_prdy, input sq_pd_prdy, sum_out_pvld);
    modport slave (input sq_pd_pvld, sum_out_prdy, output sq_pd_prdy, sum_out_pvld);
endinterface

// File: rtl/int_sum_ctrl.sv
// int_sum_ctrl: stage enables and active window length for the 2-stage int8 window-sum datapath.
// Optional perf counters (stall_cnt, drain_cnt, perf_clr) under `AUTOSA_SUM_PERF_CNT_EN.
module int_sum_ctrl
`ifdef AUTOSA_SUM_PERF_CNT_EN
#(
    parameter int PERF_CW = 32
)
`endif
(
    input  logic                autosa_core_clk,
    input  logic                autosa_core_rstn,
    input  logic [1:0]          reg2dp_normalz_len,
    int_sum_ctrl_if.slave       hs,
    output logic                load_din_d,
    output logic                load_din_2d,
    output logic                len5,
    output logic                len7,
    output logic                len9,
    output logic [1:0]          normalz_len_act,
    output logic                busy
`ifdef AUTOSA_SUM_PERF_CNT_EN
    ,
    input  logic                perf_clr,
    output logic [PERF_CW-1:0]  stall_cnt,
    output logic [PERF_CW-1:0]  drain_cnt
`endif
);
    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic       v1, v2, rst_done, adv2, mismatch, accept_en, empty;
    logic [0:0] state;
    logic [1:0] len_act;

    assign mismatch        = reg2dp_normalz_len != len_act;
    assign accept_en       = rst_done & (state == RUN) & ~mismatch;
    assign adv2            = v1 & (~v2 | hs.sum_out_prdy);
    assign hs.sq_pd_prdy   = accept_en & (~v1 | adv2);
    assign load_din_d      = hs.sq_pd_pvld & hs.sq_pd_prdy;
    assign load_din_2d     = adv2;
    assign hs.sum_out_pvld = v2;
    assign empty           = ~v1 & ~v2;
    assign busy            = v1 | v2 | (state == DRAIN);
    assign normalz_len_act = len_act;
    // Decoded from the registered length so the datapath mux never sees a mid-stream change.
    assign len5            = len_act == 2'd1;
    assign len7            = len_act == 2'd2;
    assign len9            = len_act == 2'd3;

    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            rst_done <= 1'b0;
            len_act  <= 2'h0;
            state    <= RUN;
        end else begin
            rst_done <= 1'b1;
            v1       <= load_din_d ? 1'b1 : adv2 ? 1'b0 : v1;
            v2       <= adv2 ? 1'b1 : hs.sum_out_prdy ? 1'b0 : v2;
            state    <= (state == RUN) ? (mismatch ? DRAIN : RUN) : (empty ? RUN : DRAIN);
            len_act  <= (state == DRAIN && empty) ? reg2dp_normalz_len : len_act;
        end
    end

`ifdef AUTOSA_SUM_PERF_CNT_EN
    logic stall_inc, drain_inc;
    assign stall_inc = v2 & ~hs.sum_out_prdy;
    assign drain_inc = (state == RUN) & mismatch;

    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            stall_cnt <= '0;
            drain_cnt <= '0;
        end else begin
            stall_cnt <= perf_clr ? '0 : (stall_inc & ~&stall_cnt) ? stall_cnt + 1'b1 : stall_cnt;
            drain_cnt <= perf_clr ? '0 : (drain_inc & ~&drain_cnt) ? drain_cnt + 1'b1 : drain_cnt;
        end
    end
`endif
endmodule

// File: tb/tb_int_sum_ctrl.sv
// tb_int_sum_ctrl: random and directed stimulus against a timestamp-based pipeline model.
module tb_int_sum_ctrl;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [1:0] reg2dp = 2'd0;
    logic       load_d, load_2d, len5, len7, len9, busy;
    logic [1:0] len_act;
    int_sum_ctrl_if hs();

`ifdef AUTOSA_SUM_PERF_CNT_EN
    localparam int PW = 3;
    logic          perf_clr = 1'b0;
    logic [PW-1:0] stall_cnt, drain_cnt;
    int            sc, dc;
    int_sum_ctrl #(.PERF_CW(PW)) dut (
`else
    int_sum_ctrl dut (
`endif
        .autosa_core_clk(clk),
        .autosa_core_rstn(rstn),
        .reg2dp_normalz_len(reg2dp),
        .hs(hs),
        .load_din_d(load_d),
        .load_din_2d(load_2d),
        .len5(len5),
        .len7(len7),
        .len9(len9),
        .normalz_len_act(len_act),
        .busy(busy)
`ifdef AUTOSA_SUM_PERF_CNT_EN
        ,
        .perf_clr(perf_clr),
        .stall_cnt(stall_cnt),
        .drain_cnt(drain_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails = 0;
    int t = 0;
    int lp;
    int nid = 0;
    int s1, s2;
    int iq[$];
    int aq[$];
    logic [1:0] la_m;
    logic dr_m, rd_m;
    logic [1:0] cur;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, t);
        end
    endtask

    task automatic model_reset();
        iq.delete();
        aq.delete();
        la_m = 2'd0;
        dr_m = 1'b0;
        rd_m = 1'b0;
        lp = -100;
`ifdef AUTOSA_SUM_PERF_CNT_EN
        sc = 0;
        dc = 0;
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_prdy"}, hs.sq_pd_prdy, 0);
        check({tag, "_pvld"}, hs.sum_out_pvld, 0);
        check({tag, "_load"}, {load_d, load_2d}, 0);
        check({tag, "_len"}, {len5, len7, len9, len_act}, 0);
        check({tag, "_busy"}, busy, 0);
`ifdef AUTOSA_SUM_PERF_CNT_EN
        check({tag, "_cnt"}, {stall_cnt, drain_cnt}, 0);
`endif
    endtask

    // One clock cycle: drive, compare against the model, then advance the model past the edge.
    task automatic step(input logic pv, input logic pr, input logic [1:0] rg);
        int vis;
        logic empty, pv_e, pr_e, pop, push, l2_e, pc;
        @(negedge clk);
        hs.sq_pd_pvld = pv;
        hs.sum_out_prdy = pr;
        reg2dp = rg;
        pc = ($urandom % 40) == 0;
`ifdef AUTOSA_SUM_PERF_CNT_EN
        perf_clr = pc;
`endif
        #1;
        empty = iq.size() == 0;
        vis = empty ? 0 : ((aq[0] + 2 > lp + 1) ? aq[0] + 2 : lp + 1);
        pv_e = !empty && t >= vis;
        pr_e = rd_m && !dr_m && rg == la_m && (iq.size() < 2 || pr);
        pop = pv_e && pr;
        push = pv && pr_e;
        l2_e = (!empty && t == vis - 1) || (iq.size() == 2 && pop);
        check("prdy", hs.sq_pd_prdy, pr_e);
        check("pvld", hs.sum_out_pvld, pv_e);
        check("load_d", load_d, push);
        check("load_2d", load_2d, l2_e);
        check("len_act", len_act, la_m);
        check("len_dec", {len5, len7, len9}, {la_m == 2'd1, la_m == 2'd2, la_m == 2'd3});
        check("busy", busy, !empty || dr_m);
        if (pop && hs.sum_out_pvld) check("order", s2, iq[0]);
`ifdef AUTOSA_SUM_PERF_CNT_EN
        check("stall_cnt", stall_cnt, sc);
        check("drain_cnt", drain_cnt, dc);
        sc = pc ? 0 : (pv_e && !pr && sc < (1 << PW) - 1) ? sc + 1 : sc;
        dc = pc ? 0 : (!dr_m && rg != la_m && dc < (1 << PW) - 1) ? dc + 1 : dc;
`endif
        if (load_2d) s2 = s1;
        if (load_d) s1 = nid;
        if (pop) begin
            void'(iq.pop_front());
            void'(aq.pop_front());
            lp = t;
        end
        if (push) begin
            iq.push_back(nid);
            aq.push_back(t);
            nid++;
        end
        if (!dr_m && rg != la_m) dr_m = 1'b1;
        else if (dr_m && empty) begin
            la_m = rg;
            dr_m = 1'b0;
        end
        rd_m = 1'b1;
        t++;
    endtask

    // Asynchronous assertion mid-cycle; release just after an edge so the next step sees rst_done=0.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("rst_async");
        model_reset();
        @(posedge clk);
        #1;
        check_all_zero("rst_hold");
        rstn = 1'b1;
    endtask

    initial begin
        hs.sq_pd_pvld = 1'b0;
        hs.sum_out_prdy = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst_init");
        rstn = 1'b1;
        cur = 2'd3;
        step(1, 1, cur);
        while (dr_m || busy) step(0, 1, cur);
        repeat (8) step(1, 1, cur);
        repeat (4) step(0, 1, cur);
        for (int i = 0; i < 16; i++) step(i < 12, !(i >= 4 && i < 7), cur);
        repeat (4) step(0, 1, cur);
        repeat (4) step(1, 1, cur);
        cur = 2'd1;
        repeat (8) step(1, 1, cur);
        repeat (4) step(0, 1, cur);
        repeat (6) step(1, 0, cur);
        repeat (3) step(0, 1, cur);
        cur = 2'd0;
        repeat (6) step(0, 1, cur);
        step(1, 1, cur);
        repeat (4) step(0, 1, cur);
        repeat (4) step(1, 0, cur);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 50 == 0) cur = 2'($urandom % 4);
            step(($urandom % 4) != 0, ($urandom % 3) != 0, cur);
            if (i == 1500) do_reset();
        end
        repeat (6) step(0, 1, cur);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
